// File: rtl/pkt_rx_parser_pkg.sv
// Shared types and constants for the receive byte-stream parser.
// Packet types, header offsets, error codes and FSM states.
package pkt_rx_parser_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CH   = 3'b001;
  localparam logic [2:0] PKT_JOIN = 3'b010;
  localparam logic [2:0] PKT_ACK  = 3'b011;
  localparam logic [2:0] PKT_QT   = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;
  localparam logic [2:0] PKT_SOS  = 3'b110;

  localparam logic [1:0] HDR_SRC_HI = 2'd0;
  localparam logic [1:0] HDR_SRC_LO = 2'd1;
  localparam logic [1:0] HDR_DST_HI = 2'd2;
  localparam logic [1:0] HDR_DST_LO = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SOP      = 2'b01;
  localparam logic [1:0] ERR_OVERSIZE = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_PAYLOAD,
    S_EMIT,
    S_DROP
  } state_e;

  function automatic logic [2:0] b0_type(
    input logic [7:0] b
  );
    return b[7:5];
  endfunction

endpackage

// File: rtl/pkt_rx_parser_if.sv
// Radio byte-stream handshake between the receiver and the parser.
// accept = rx_valid & rx_ready.
interface pkt_rx_parser_if;
  logic       rx_valid;
  logic       rx_sop;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_sop,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_sop,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/pkt_rx_parser_buf.sv
// Payload register file: one write port, one combinational read port.
// Cleared by reset so the read port shows 0 after reset.
module pkt_payload_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pkt_rx_parser.sv
// Receive parser: assembles header fields, buffers payload,
// drops malformed, oversize and stalled packets.
module pkt_rx_parser
  import pkt_rx_parser_pkg::*;
#(
  parameter int PAYLOAD_MAX = 32,
  parameter int TIMEOUT     = 255,
  localparam int AW = $clog2(PAYLOAD_MAX),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  pkt_rx_parser_if.slave rx,
  output logic          newpkt,
  output logic [2:0]    fPktType,
  output logic [15:0]   sourceID,
  output logic [15:0]   destinationID,
  output logic [7:0]    pl_len,
  input  logic [AW-1:0] pl_raddr,
  output logic [7:0]    pl_rdata,
  output logic          pkt_err,
  output logic [1:0]    err_code
);

  state_e        state_q, state_d;
  logic [1:0]    hcnt_q, hcnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [2:0]    typ_sh_q, typ_sh_d;
  logic [15:0]   src_sh_q, src_sh_d;
  logic [15:0]   dst_sh_q, dst_sh_d;
  logic [7:0]    len_q, len_d;
  logic          newpkt_q, newpkt_d;
  logic [2:0]    ftype_q, ftype_d;
  logic [15:0]   src_q, src_d;
  logic [15:0]   dst_q, dst_d;
  logic [7:0]    pllen_q, pllen_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          acc, busy, tmo, we;

  assign rx.rx_ready = ~nrst & (state_q != S_EMIT);
  assign acc  = rx.rx_valid & rx.rx_ready;
  assign busy = (state_q == S_HDR) | (state_q == S_LEN)
              | (state_q == S_PAYLOAD);
  assign tmo  = busy & (idle_q == TW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    idx_d    = idx_q;
    idle_d   = '0;
    typ_sh_d = typ_sh_q;
    src_sh_d = src_sh_q;
    dst_sh_d = dst_sh_q;
    len_d    = len_q;
    newpkt_d = 1'b0;
    ftype_d  = ftype_q;
    src_d    = src_q;
    dst_d    = dst_q;
    pllen_d  = pllen_q;
    err_d    = 1'b0;
    code_d   = code_q;
    we       = 1'b0;

    if (busy && !acc) idle_d = idle_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_DROP: begin
        if (acc && rx.rx_sop) begin
          typ_sh_d = b0_type(rx.rx_data);
          hcnt_d   = '0;
          state_d  = S_HDR;
        end
      end
      S_HDR, S_LEN, S_PAYLOAD: begin
        // sop-abort outranks timeout; the sop byte starts a new packet
        if (acc && rx.rx_sop) begin
          err_d    = 1'b1;
          code_d   = ERR_SOP;
          typ_sh_d = b0_type(rx.rx_data);
          hcnt_d   = '0;
          state_d  = S_HDR;
        end else if (tmo) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = S_IDLE;
        end else if (acc) begin
          if (state_q == S_HDR) begin
            hcnt_d = hcnt_q + 1'b1;
            unique case (hcnt_q)
              HDR_SRC_HI: src_sh_d[15:8] = rx.rx_data;
              HDR_SRC_LO: src_sh_d[7:0]  = rx.rx_data;
              HDR_DST_HI: dst_sh_d[15:8] = rx.rx_data;
              HDR_DST_LO: begin
                dst_sh_d[7:0] = rx.rx_data;
                state_d       = S_LEN;
              end
              default: ;
            endcase
          end else if (state_q == S_LEN) begin
            len_d = rx.rx_data;
            idx_d = '0;
            if (rx.rx_data > 8'(PAYLOAD_MAX)) begin
              err_d   = 1'b1;
              code_d  = ERR_OVERSIZE;
              state_d = S_DROP;
            end else if (rx.rx_data == 8'd0) begin
              state_d = S_EMIT;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else begin
            we    = 1'b1;
            idx_d = idx_q + 1'b1;
            if (8'(idx_q) == len_q - 8'd1) state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        newpkt_d = 1'b1;
        ftype_d  = typ_sh_q;
        src_d    = src_sh_q;
        dst_d    = dst_sh_q;
        pllen_d  = len_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      idx_q    <= '0;
      idle_q   <= '0;
      typ_sh_q <= '0;
      src_sh_q <= '0;
      dst_sh_q <= '0;
      len_q    <= '0;
      newpkt_q <= 1'b0;
      ftype_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      pllen_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      idx_q    <= idx_d;
      idle_q   <= idle_d;
      typ_sh_q <= typ_sh_d;
      src_sh_q <= src_sh_d;
      dst_sh_q <= dst_sh_d;
      len_q    <= len_d;
      newpkt_q <= newpkt_d;
      ftype_q  <= ftype_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      pllen_q  <= pllen_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  pkt_payload_buf #(
    .DEPTH (PAYLOAD_MAX)
  ) u_buf (
    .clk     (clk),
    .rst     (nrst),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (rx.rx_data),
    .raddr_i (pl_raddr),
    .rdata_o (pl_rdata)
  );

  assign newpkt        = newpkt_q;
  assign fPktType      = ftype_q;
  assign sourceID      = src_q;
  assign destinationID = dst_q;
  assign pl_len        = pllen_q;
  assign pkt_err       = err_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Directed bench for pkt_rx_parser: good, oversize, sop-abort,
// timeout and async-reset packets with hand-computed fields.
module tb_pkt_rx_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [4:0]  pl_raddr = '0;
  logic        newpkt, pkt_err;
  logic [2:0]  fPktType;
  logic [15:0] sourceID, destinationID;
  logic [7:0]  pl_len, pl_rdata;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_err = 0;
  int np_cnt = 0;
  int er_cnt = 0;
  logic [2:0]  cap_t;
  logic [15:0] cap_s, cap_d;
  logic [7:0]  cap_l;
  logic [1:0]  cap_c;

  pkt_rx_parser_if rxif();

  pkt_rx_parser dut (
    .clk           (clk),
    .nrst          (nrst),
    .rx            (rxif),
    .newpkt        (newpkt),
    .fPktType      (fPktType),
    .sourceID      (sourceID),
    .destinationID (destinationID),
    .pl_len        (pl_len),
    .pl_raddr      (pl_raddr),
    .pl_rdata      (pl_rdata),
    .pkt_err       (pkt_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (newpkt) begin
      np_cnt++;
      cap_t = fPktType;
      cap_s = sourceID;
      cap_d = destinationID;
      cap_l = pl_len;
    end
    if (pkt_err) begin
      er_cnt++;
      cap_c = err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    rxif.rx_valid = 1'b1;
    rxif.rx_sop   = s;
    rxif.rx_data  = d;
    while (!rxif.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rdy_wait", 32'(n), 0);
    @(posedge clk);
    #1;
    rxif.rx_valid = 1'b0;
    rxif.rx_sop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b [], input int gap);
    foreach (b[i]) begin
      send(b[i], i == 0);
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] p [];
    int n;
    rxif.rx_valid = 1'b0;
    rxif.rx_sop   = 1'b0;
    rxif.rx_data  = '0;

    repeat (2) @(negedge clk);
    chk("rst_rdy", rxif.rx_ready, 0);
    chk("rst_newpkt", newpkt, 0);
    chk("rst_err", pkt_err, 0);
    chk("rst_src", sourceID, 0);
    nrst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", rxif.rx_ready, 1);

    // 1: HB, len 0
    p = '{8'h00, 8'h00, 8'h07, 8'hFF, 8'hFF, 8'h00};
    send_pkt(p, 0);
    @(negedge clk);
    chk("t1_lat_n1", newpkt, 0);
    chk("t1_emit_rdy", rxif.rx_ready, 0);
    @(negedge clk);
    chk("t1_lat_n2", newpkt, 1);
    chk("t1_type", fPktType, 3'b000);
    chk("t1_src", sourceID, 16'h0007);
    chk("t1_dst", destinationID, 16'hFFFF);
    chk("t1_len", pl_len, 0);
    repeat (3) @(negedge clk);
    chk("t1_pulses", np_cnt, 1);
    chk("t1_hold", sourceID, 16'h0007);

    // 2: data packet with valid gaps
    p = '{8'hA0, 8'h00, 8'h03, 8'h00, 8'h05, 8'h03,
          8'h11, 8'h22, 8'h33};
    send_pkt(p, 2);
    repeat (3) @(negedge clk);
    chk("t2_pulses", np_cnt, 2);
    chk("t2_type", cap_t, 3'b101);
    chk("t2_src", cap_s, 16'h0003);
    chk("t2_dst", cap_d, 16'h0005);
    chk("t2_len", cap_l, 3);
    pl_raddr = 5'd2;
    #1;
    chk("t2_pl2", pl_rdata, 8'h33);
    pl_raddr = 5'd0;
    #1;
    chk("t2_pl0", pl_rdata, 8'h11);

    // 3: oversize length 0x21
    p = '{8'h20, 8'h00, 8'h01, 8'h00, 8'h02, 8'h21,
          8'h55, 8'h66, 8'h77};
    send_pkt(p, 0);
    repeat (3) @(negedge clk);
    chk("t3_errs", er_cnt, 1);
    chk("t3_code", err_code, 2'b10);
    chk("t3_nopkt", np_cnt, 2);
    chk("t3_fields_hold", fPktType, 3'b101);

    // 4: sop at B3 position restarts packet
    p = '{8'h20, 8'h00, 8'h01};
    send_pkt(p, 0);
    p = '{8'hC0, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h00};
    send_pkt(p, 0);
    repeat (3) @(negedge clk);
    chk("t4_errs", er_cnt, 2);
    chk("t4_code", cap_c, 2'b01);
    chk("t4_pulses", np_cnt, 3);
    chk("t4_type", cap_t, 3'b110);
    chk("t4_src", cap_s, 16'h0009);
    chk("t4_dst", cap_d, 16'h000A);

    // 5: stall after B2
    p = '{8'h40, 8'h12, 8'h34};
    send_pkt(p, 0);
    n = 0;
    while (!pkt_err && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_tmo_cycles", n, 256);
    chk("t5_code", err_code, 2'b11);
    send(8'h99, 1'b0);
    p = '{8'h60, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h77};
    send_pkt(p, 0);
    repeat (3) @(negedge clk);
    chk("t5_errs", er_cnt, 3);
    chk("t5_pulses", np_cnt, 4);
    chk("t5_type", cap_t, 3'b011);
    chk("t5_src", cap_s, 16'hABCD);
    chk("t5_dst", cap_d, 16'h1234);
    chk("t5_pl0", pl_rdata, 8'h77);

    // 6: async reset mid-payload
    p = '{8'h20, 8'h00, 8'h05, 8'h00, 8'h06, 8'h04,
          8'h01, 8'h02};
    send_pkt(p, 0);
    #2;
    nrst = 1'b1;
    #1;
    chk("t6_newpkt", newpkt, 0);
    chk("t6_err", pkt_err, 0);
    chk("t6_code", err_code, 0);
    chk("t6_type", fPktType, 0);
    chk("t6_src", sourceID, 0);
    chk("t6_dst", destinationID, 0);
    chk("t6_len", pl_len, 0);
    chk("t6_pl", pl_rdata, 0);
    chk("t6_rdy", rxif.rx_ready, 0);
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_no_pulse", np_cnt, 4);
    chk("t6_no_err", er_cnt, 3);
    p = '{8'hA0, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h5A};
    send_pkt(p, 0);
    repeat (3) @(negedge clk);
    chk("t6_pulses", np_cnt, 5);
    chk("t6_ntype", fPktType, 3'b101);
    chk("t6_nsrc", sourceID, 16'h0001);
    chk("t6_ndst", destinationID, 16'h0002);
    chk("t6_nlen", pl_len, 1);
    chk("t6_npl", pl_rdata, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
